// File: rtl/card_store.sv
// Prepaid phone card responder: answers the billing unit's read/write
// handshake from a stored BCD balance and accepts top-up loads while
// the card is out of the phone.
module card_store #(
    parameter int unsigned RD_LAT   = 3,
    parameter int unsigned WR_LAT   = 10,
    parameter logic [11:0] INIT_BAL = 12'h000
) (
    input  logic        clk_1kHz,
    input  logic        clrn,
    input  logic        card,
    input  logic        read,
    input  logic        write,
    input  logic [11:0] wdata,
    input  logic        load,
    input  logic [11:0] load_data,
    output logic [11:0] rdata,
    output logic        ack,
    output logic        busy,
    output logic        err
);

    localparam int unsigned DW = 12;
    localparam int unsigned CW = 4;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RD_WAIT = 2'd1,
        WR_WAIT = 2'd2,
        HOLD    = 2'd3
    } state_t;

    state_t          state, state_n;
    logic [CW-1:0]   cnt, cnt_n;
    logic [DW-1:0]   balance, balance_n;
    logic [DW-1:0]   shadow, shadow_n;
    logic            hold_wr, hold_wr_n;
    logic [DW-1:0]   rdata_n;
    logic            ack_n, busy_n, err_n;

    logic idle, rd_go, wr_go, rw_clash, rd_done, wr_done, wr_bad;
    logic abort, tear, hold_rel, load_ok, load_err;

    // True when every nibble is a decimal digit
    function automatic logic bcd_ok(input logic [DW-1:0] v);
        return (v[3:0] <= 4'd9) && (v[7:4] <= 4'd9) && (v[11:8] <= 4'd9);
    endfunction

    // Shared event decode; packed valid BCD orders the same as its value
    assign idle     = (state == IDLE);
    assign rd_go    = idle && card && read && !write;
    assign wr_go    = idle && card && write && !read;
    assign rw_clash = idle && card && read && write;
    assign abort    = !idle && !card;
    assign tear     = (state == WR_WAIT) && !card;
    assign rd_done  = (state == RD_WAIT) && card && (cnt == CW'(RD_LAT - 1));
    assign wr_done  = (state == WR_WAIT) && card && (cnt == CW'(WR_LAT - 1));
    assign wr_bad   = !bcd_ok(shadow) || (shadow > balance);
    assign hold_rel = (state == HOLD) && card && !(hold_wr ? write : read);
    assign load_ok  = load && idle && !card && bcd_ok(load_data);
    assign load_err = load && !load_ok;

    // State and registered outputs
    always_ff @(posedge clk_1kHz or negedge clrn) begin
        if (!clrn) begin
            state   <= IDLE;
            cnt     <= '0;
            balance <= INIT_BAL;
            shadow  <= '0;
            hold_wr <= 1'b0;
            rdata   <= '0;
            ack     <= 1'b0;
            busy    <= 1'b0;
            err     <= 1'b0;
        end else begin
            state   <= state_n;
            cnt     <= cnt_n;
            balance <= balance_n;
            shadow  <= shadow_n;
            hold_wr <= hold_wr_n;
            rdata   <= rdata_n;
            ack     <= ack_n;
            busy    <= busy_n;
            err     <= err_n;
        end
    end

    // Next-state selection; card removal always returns to IDLE
    always_comb begin
        state_n = state;
        case (state)
            IDLE: begin
                if (rd_go)      state_n = RD_WAIT;
                else if (wr_go) state_n = WR_WAIT;
            end
            RD_WAIT: begin
                if (!card)        state_n = IDLE;
                else if (rd_done) state_n = HOLD;
            end
            WR_WAIT: begin
                if (!card)        state_n = IDLE;
                else if (wr_done) state_n = HOLD;
            end
            HOLD: begin
                if (!card || hold_rel) state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    // Datapath and output next values
    always_comb begin
        cnt_n     = cnt;
        balance_n = balance;
        shadow_n  = shadow;
        hold_wr_n = hold_wr;
        rdata_n   = rdata;
        ack_n     = ack;
        busy_n    = (state_n != IDLE);
        err_n     = rw_clash || load_err || tear || (wr_done && wr_bad);

        if (state == RD_WAIT || state == WR_WAIT)
            cnt_n = cnt + CW'(1);
        if (rd_go) begin
            cnt_n     = '0;
            hold_wr_n = 1'b0;
        end
        if (wr_go) begin
            cnt_n     = '0;
            shadow_n  = wdata;
            hold_wr_n = 1'b1;
        end
        if (rd_done) begin
            rdata_n = balance;
            ack_n   = 1'b1;
        end
        if (wr_done) begin
            ack_n = 1'b1;
            if (!wr_bad)
                balance_n = shadow;
        end
        if (abort || hold_rel)
            ack_n = 1'b0;
        if (load_ok)
            balance_n = load_data;
    end

endmodule

// File: tb/tb_card_store.sv
// Bench for card_store: a table of card transactions driven in order,
// each pushing its expected outcome to a scoreboard that is popped and
// compared once the DUT has finished the access.
module tb_card_store;

    typedef enum int {K_LOAD, K_READ, K_WRITE, K_BOTH} kind_t;

    typedef struct {
        kind_t       kind;
        logic        crd;
        logic [11:0] data;
        int          drop;
        bit          mid;
        logic [11:0] exp_rdata;
        int          exp_lat;
        int          exp_err;
    } vec_t;

    typedef struct {
        logic [11:0] rdata;
        int          lat;
        int          err;
    } exp_t;

    logic        clk_1kHz = 1'b0;
    logic        clrn = 1'b1;
    logic        card = 1'b0;
    logic        read = 1'b0;
    logic        write = 1'b0;
    logic [11:0] wdata = 12'h000;
    logic        load = 1'b0;
    logic [11:0] load_data = 12'h000;
    logic [11:0] rdata;
    logic        ack, busy, err;

    int   checks = 0;
    int   failures = 0;
    int   err_cnt = 0;
    vec_t vecs[$];
    exp_t sb[$];

    card_store #(.RD_LAT(3), .WR_LAT(10), .INIT_BAL(12'h000)) dut (
        .clk_1kHz  (clk_1kHz),
        .clrn      (clrn),
        .card      (card),
        .read      (read),
        .write     (write),
        .wdata     (wdata),
        .load      (load),
        .load_data (load_data),
        .rdata     (rdata),
        .ack       (ack),
        .busy      (busy),
        .err       (err)
    );

    always #5 clk_1kHz = ~clk_1kHz;

    // Count err pulses, sampled shortly after each rising edge
    always @(posedge clk_1kHz) begin
        #2;
        if (err === 1'b1) err_cnt++;
    end

    initial begin
        #100000;
        $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", name, got, exp);
        end
    endtask

    function automatic vec_t mk(input kind_t k, input logic c, input logic [11:0] d,
                                input int drop, input bit mid, input logic [11:0] er,
                                input int el, input int ee);
        vec_t v;
        v.kind = k; v.crd = c; v.data = d; v.drop = drop; v.mid = mid;
        v.exp_rdata = er; v.exp_lat = el; v.exp_err = ee;
        return v;
    endfunction

    // Drive one transaction starting at a falling edge; ends at a falling edge
    task automatic run_vec(input vec_t v, input int idx);
        exp_t e;
        int   lat = 0;
        int   e0;
        logic got_ack = 1'b0;
        e.rdata = v.exp_rdata; e.lat = v.exp_lat; e.err = v.exp_err;
        sb.push_back(e);
        e0 = err_cnt;
        case (v.kind)
            K_LOAD: begin
                card = v.crd; load = 1'b1; load_data = v.data;
                @(negedge clk_1kHz);
                load = 1'b0;
                @(negedge clk_1kHz);
            end
            K_BOTH: begin
                card = 1'b1; read = 1'b1; write = 1'b1;
                @(negedge clk_1kHz);
                chk($sformatf("v%0d busy_clash", idx), int'(busy), 0);
                read = 1'b0; write = 1'b0;
                @(negedge clk_1kHz);
            end
            default: begin
                card = 1'b1;
                if (v.kind == K_WRITE) begin write = 1'b1; wdata = v.data; end
                else read = 1'b1;
                @(negedge clk_1kHz);
                chk($sformatf("v%0d busy_accept", idx), int'(busy), 1);
                while (lat < 40) begin
                    if (v.drop != 0 && lat == v.drop - 1) card = 1'b0;
                    if (v.mid && lat == 2) wdata = 12'h999;
                    @(negedge clk_1kHz);
                    lat++;
                    if (ack || !busy) break;
                end
                got_ack = ack;
                if (got_ack) begin
                    @(negedge clk_1kHz);
                    chk($sformatf("v%0d ack_hold", idx), int'(ack), 1);
                end
                read = 1'b0; write = 1'b0;
                @(negedge clk_1kHz);
                chk($sformatf("v%0d ack_release", idx), int'(ack), 0);
                chk($sformatf("v%0d busy_release", idx), int'(busy), 0);
            end
        endcase
        e = sb.pop_front();
        if (v.kind == K_READ || v.kind == K_WRITE)
            chk($sformatf("v%0d ack_latency", idx), got_ack ? lat : 0, e.lat);
        chk($sformatf("v%0d err_pulses", idx), err_cnt - e0, e.err);
        chk($sformatf("v%0d rdata", idx), int'(rdata), int'(e.rdata));
    endtask

    initial begin
        vecs.push_back(mk(K_LOAD,  1'b0, 12'h100, 0, 1'b0, 12'h000, 0,  0));
        vecs.push_back(mk(K_READ,  1'b1, 12'h000, 0, 1'b0, 12'h100, 3,  0));
        vecs.push_back(mk(K_WRITE, 1'b1, 12'h095, 0, 1'b0, 12'h100, 10, 0));
        vecs.push_back(mk(K_READ,  1'b1, 12'h000, 0, 1'b0, 12'h095, 3,  0));
        vecs.push_back(mk(K_WRITE, 1'b1, 12'h120, 0, 1'b0, 12'h095, 10, 1));
        vecs.push_back(mk(K_READ,  1'b1, 12'h000, 0, 1'b0, 12'h095, 3,  0));
        vecs.push_back(mk(K_WRITE, 1'b1, 12'h0A0, 0, 1'b0, 12'h095, 10, 1));
        vecs.push_back(mk(K_READ,  1'b1, 12'h000, 0, 1'b0, 12'h095, 3,  0));
        vecs.push_back(mk(K_WRITE, 1'b1, 12'h080, 5, 1'b0, 12'h095, 0,  1));
        vecs.push_back(mk(K_READ,  1'b1, 12'h000, 0, 1'b0, 12'h095, 3,  0));
        vecs.push_back(mk(K_BOTH,  1'b1, 12'h000, 0, 1'b0, 12'h095, 0,  1));
        vecs.push_back(mk(K_LOAD,  1'b1, 12'h050, 0, 1'b0, 12'h095, 0,  1));
        vecs.push_back(mk(K_READ,  1'b1, 12'h000, 0, 1'b0, 12'h095, 3,  0));
        vecs.push_back(mk(K_LOAD,  1'b0, 12'h1A0, 0, 1'b0, 12'h095, 0,  1));
        vecs.push_back(mk(K_READ,  1'b1, 12'h000, 0, 1'b0, 12'h095, 3,  0));
        vecs.push_back(mk(K_WRITE, 1'b1, 12'h000, 0, 1'b0, 12'h095, 10, 0));
        vecs.push_back(mk(K_READ,  1'b1, 12'h000, 0, 1'b0, 12'h000, 3,  0));
        vecs.push_back(mk(K_LOAD,  1'b0, 12'h123, 0, 1'b0, 12'h000, 0,  0));
        vecs.push_back(mk(K_READ,  1'b1, 12'h000, 2, 1'b0, 12'h000, 0,  0));
        vecs.push_back(mk(K_READ,  1'b1, 12'h000, 0, 1'b0, 12'h123, 3,  0));
        vecs.push_back(mk(K_WRITE, 1'b1, 12'h100, 0, 1'b1, 12'h123, 10, 0));
        vecs.push_back(mk(K_READ,  1'b1, 12'h000, 0, 1'b0, 12'h100, 3,  0));
        vecs.push_back(mk(K_WRITE, 1'b1, 12'h100, 0, 1'b0, 12'h100, 10, 0));
        vecs.push_back(mk(K_READ,  1'b1, 12'h000, 0, 1'b0, 12'h100, 3,  0));

        // Asynchronous reset takes effect before any clock edge
        #1 clrn = 1'b0;
        #1;
        chk("reset_rdata", int'(rdata), 12'h000);
        chk("reset_ack",   int'(ack),   0);
        chk("reset_busy",  int'(busy),  0);
        chk("reset_err",   int'(err),   0);
        repeat (3) @(negedge clk_1kHz);
        clrn = 1'b1;
        @(negedge clk_1kHz);

        foreach (vecs[i]) run_vec(vecs[i], i);

        // Reset in the middle of a write drops it and restores INIT_BAL
        card = 1'b1; write = 1'b1; wdata = 12'h050;
        repeat (3) @(negedge clk_1kHz);
        chk("midreset_busy_before", int'(busy), 1);
        #1 clrn = 1'b0;
        #1;
        chk("midreset_busy",  int'(busy),  0);
        chk("midreset_ack",   int'(ack),   0);
        chk("midreset_rdata", int'(rdata), 12'h000);
        write = 1'b0; card = 1'b0;
        @(negedge clk_1kHz);
        clrn = 1'b1;
        @(negedge clk_1kHz);
        run_vec(mk(K_READ, 1'b1, 12'h000, 0, 1'b0, 12'h000, 3, 0), 99);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
